// File: rtl/motor_pkg.sv
// Shared motor_driver definitions: pulse-generator state encoding, clock/PWM
// defaults and the longest low phase the encoder receiver still reads as moving.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pg_state_t;

  localparam int unsigned DEF_CLOCK_FREQ_HZ      = 100_000_000;
  localparam int unsigned DEF_PWM_PERIOD_FREQ_HZ = 2_000;

  // A low phase longer than one slowest-PWM period reads as "motor stopped".
  function automatic int unsigned calc_max_low(input int unsigned clk_hz,
                                               input int unsigned pwm_hz);
    return clk_hz / pwm_hz;
  endfunction

endpackage

// File: rtl/enc_cfg_slot.sv
// Pending configuration slot: clamps and holds one high/low setting until the
// pulse generator pulls it into its active registers.
module enc_cfg_slot
  import motor_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned MAX_LOW   = 50_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] i_cfg_high,
  input  logic [CNT_WIDTH-1:0] i_cfg_low,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic                 i_load,
  output logic [CNT_WIDTH-1:0] o_pend_high,
  output logic [CNT_WIDTH-1:0] o_pend_low,
  output logic                 o_pend_v,
  output logic                 o_cfg_clamped
);

  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MAX_LOW_W = CNT_WIDTH'(MAX_LOW);

  logic [CNT_WIDTH-1:0] r_pend_high;
  logic [CNT_WIDTH-1:0] r_pend_low;
  logic                 r_pend_v;
  logic                 r_cfg_clamped;
  logic                 w_accept;
  logic                 w_clamp_hit;

  function automatic logic [CNT_WIDTH-1:0] clamp_high(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] clamp_low(input logic [CNT_WIDTH-1:0] v);
    if (v == '0)           return ONE;
    else if (v > MAX_LOW_W) return MAX_LOW_W;
    else                   return v;
  endfunction

  assign w_accept    = i_cfg_valid && !r_pend_v;
  assign w_clamp_hit = (i_cfg_high == '0) || (i_cfg_low == '0) || (i_cfg_low > MAX_LOW_W);

  // Accept and load are mutually exclusive: accept needs an empty slot, load a full one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_high   <= '0;
      r_pend_low    <= '0;
      r_pend_v      <= 1'b0;
      r_cfg_clamped <= 1'b0;
    end else begin
      r_cfg_clamped <= w_accept && w_clamp_hit;
      if (w_accept) begin
        r_pend_high <= clamp_high(i_cfg_high);
        r_pend_low  <= clamp_low(i_cfg_low);
        r_pend_v    <= 1'b1;
      end else if (i_load) begin
        r_pend_v    <= 1'b0;
      end
    end
  end

  assign o_cfg_ready   = !r_pend_v;
  assign o_pend_high   = r_pend_high;
  assign o_pend_low    = r_pend_low;
  assign o_pend_v      = r_pend_v;
  assign o_cfg_clamped = r_cfg_clamped;

endmodule

// File: rtl/encoder_pulse_gen.sv
// Programmable square-wave source (PWM / Hall-encoder emulator) whose high and
// low lengths in clock cycles change only on a period boundary.
module encoder_pulse_gen
  import motor_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ      = DEF_CLOCK_FREQ_HZ,
  parameter int unsigned PWM_PERIOD_FREQ_HZ = DEF_PWM_PERIOD_FREQ_HZ,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] cfg_high,
  input  logic [CNT_WIDTH-1:0] cfg_low,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 pulse_out,
  output logic                 running,
  output logic                 period_done,
  output logic                 cfg_clamped
);

  localparam int unsigned          MAX_LOW = calc_max_low(CLOCK_FREQ_HZ, PWM_PERIOD_FREQ_HZ);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  pg_state_t            r_state;
  pg_state_t            w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_act_high;
  logic [CNT_WIDTH-1:0] r_act_low;
  logic                 r_act_v;
  logic                 r_pulse;
  logic                 w_load;
  logic                 w_period_done;
  logic [CNT_WIDTH-1:0] w_pend_high;
  logic [CNT_WIDTH-1:0] w_pend_low;
  logic                 w_pend_v;

  enc_cfg_slot #(
    .CNT_WIDTH (CNT_WIDTH),
    .MAX_LOW   (MAX_LOW)
  ) u_cfg_slot (
    .clk           (clk),
    .reset         (reset),
    .i_cfg_high    (cfg_high),
    .i_cfg_low     (cfg_low),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_load        (w_load),
    .o_pend_high   (w_pend_high),
    .o_pend_low    (w_pend_low),
    .o_pend_v      (w_pend_v),
    .o_cfg_clamped (cfg_clamped)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_load        = 1'b0;
    w_period_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load = w_pend_v;
        if (enable && r_act_v) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = ONE;
        end
      end
      ST_HIGH: begin
        if (r_cnt == r_act_high) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = ONE;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
        end
      end
      ST_LOW: begin
        if (r_cnt == r_act_low) begin
          w_period_done = 1'b1;
          w_load        = w_pend_v;
          if (enable) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = ONE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A phase that starts on a boundary uses the values loaded on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_act_high <= '0;
      r_act_low  <= '0;
      r_act_v    <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= (w_state_nxt == ST_HIGH);
      if (w_load) begin
        r_act_high <= w_pend_high;
        r_act_low  <= w_pend_low;
        r_act_v    <= 1'b1;
      end
    end
  end

  assign pulse_out   = r_pulse;
  assign running     = (r_state == ST_HIGH) || (r_state == ST_LOW);
  assign period_done = w_period_done;

endmodule

// File: tb/tb_encoder_pulse_gen.sv
// Scoreboard bench for encoder_pulse_gen: stimulus queues expected period
// lengths, a monitor measures each completed period and compares.
module tb_encoder_pulse_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] cfg_high;
  logic [31:0] cfg_low;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        pulse_out;
  logic        running;
  logic        period_done;
  logic        cfg_clamped;

  encoder_pulse_gen dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_high    (cfg_high),
    .cfg_low     (cfg_low),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .pulse_out   (pulse_out),
    .running     (running),
    .period_done (period_done),
    .cfg_clamped (cfg_clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
  } per_t;

  per_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  int   n_clamp  = 0;
  int   h_cnt    = 0;
  int   l_cnt    = 0;
  logic last_ready_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: measure each period and compare against the queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      h_cnt = 0;
      l_cnt = 0;
    end else begin
      if (pulse_out)    h_cnt++;
      else if (running) l_cnt++;
      if (cfg_clamped)  n_clamp++;
      if (period_done) begin
        n_done++;
        last_ready_done = cfg_ready;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL period_unexpected: got %0d high / %0d low, expected no period", h_cnt, l_cnt);
        end else begin
          per_t e;
          e = exp_q.pop_front();
          chk($sformatf("period%0d_high", n_done), h_cnt, e.h);
          chk($sformatf("period%0d_low", n_done), l_cnt, e.l);
        end
        h_cnt = 0;
        l_cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cfg(input int h, input int l);
    int n;
    n = 0;
    cfg_high  = h;
    cfg_low   = l;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (n_done < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("wait_done_%0d", target), n_done, target);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen_high;
    reset     = 1'b1;
    enable    = 1'b0;
    cfg_high  = '0;
    cfg_low   = '0;
    cfg_valid = 1'b0;
    tick(2);
    @(negedge clk);
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_running", running, 0);
    chk("rst_period_done", period_done, 0);
    chk("rst_cfg_clamped", cfg_clamped, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    reset = 1'b0;
    tick(1);

    // 3/5 start-up and steady periods
    enable = 1'b1;
    repeat (3) exp_q.push_back('{3, 5});
    send_cfg(3, 5);
    @(negedge clk);
    chk("t1_ready_low", cfg_ready, 0);
    chk("t1_pulse_n1", pulse_out, 0);
    tick(1);
    @(negedge clk);
    chk("t1_ready_back", cfg_ready, 1);
    chk("t1_pulse_n1b", pulse_out, 0);
    tick(1);
    @(negedge clk);
    chk("t1_pulse_rise", pulse_out, 1);
    chk("t1_running", running, 1);
    wait_done(3, 100);

    // reconfigure to 2/2 in the middle of a 3/5 high phase
    exp_q.push_back('{3, 5});
    repeat (3) exp_q.push_back('{2, 2});
    tick(1);
    send_cfg(2, 2);
    @(negedge clk);
    chk("t2_ready_low", cfg_ready, 0);
    wait_done(4, 50);
    chk("t2_ready_at_boundary", last_ready_done, 0);
    @(negedge clk);
    chk("t2_ready_after_boundary", cfg_ready, 1);
    chk("t2_pulse_after_boundary", pulse_out, 1);
    wait_done(6, 50);
    enable = 1'b0;
    wait_done(7, 50);
    @(negedge clk);
    chk("t2_idle_running", running, 0);
    chk("t2_idle_pulse", pulse_out, 0);

    // clamp 0/70000 -> 1/50000
    exp_q.push_back('{1, 50000});
    send_cfg(0, 70000);
    @(negedge clk);
    chk("t3_clamped_pulse", cfg_clamped, 1);
    tick(1);
    @(negedge clk);
    chk("t3_clamped_once", cfg_clamped, 0);
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    wait_done(8, 60000);

    // enable drops on 2nd high cycle of 4/4
    send_cfg(4, 4);
    tick(1);
    enable = 1'b1;
    tick(1);
    @(negedge clk);
    chk("t4_pulse_high1", pulse_out, 1);
    tick(1);
    enable = 1'b0;
    exp_q.push_back('{4, 4});
    wait_done(9, 50);
    @(negedge clk);
    chk("t4_idle_running", running, 0);
    chk("t4_idle_pulse", pulse_out, 0);
    enable = 1'b1;
    tick(1);
    @(negedge clk);
    chk("t4_reenable_rise", pulse_out, 1);

    // accept 1/1 exactly on the period_done cycle of a 4/4 period
    exp_q.push_back('{4, 4});
    exp_q.push_back('{4, 4});
    exp_q.push_back('{1, 1});
    tick(7);
    @(negedge clk);
    chk("t5_on_boundary", period_done, 1);
    send_cfg(1, 1);
    wait_done(11, 50);
    enable = 1'b0;
    wait_done(12, 50);
    @(negedge clk);
    chk("t5_idle_running", running, 0);

    // reset in the middle of a low phase
    send_cfg(3, 5);
    tick(1);
    enable = 1'b1;
    tick(1);
    tick(4);
    @(negedge clk);
    chk("t6_mid_low_running", running, 1);
    chk("t6_mid_low_pulse", pulse_out, 0);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    chk("t6_rst_pulse", pulse_out, 0);
    chk("t6_rst_running", running, 0);
    chk("t6_rst_ready", cfg_ready, 1);
    chk("t6_rst_act_v", dut.r_act_v, 0);
    reset = 1'b0;
    seen_high = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      @(negedge clk);
      if (pulse_out || running) seen_high++;
    end
    chk("t6_no_restart", seen_high, 0);
    enable = 1'b0;

    chk("final_periods", n_done, 12);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_clamp_count", n_clamp, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/encoder_pulse_gen.md
# encoder_pulse_gen

Programmable pulse generator that is the transmit-side counterpart of the motor driver's encoder measurement channel. It drives a square wave with exactly commanded high and low periods, in clock cycles. The block serves as a motor-drive PWM source and as a Hall-encoder emulator for closed-loop bring-up without a physical motor. It sits in the motor_driver IP next to the encoder measurement channel. It is configured by the controller through a valid/ready handshake, and a new setting takes effect only on a period boundary.

## Interface
- CLOCK_FREQ_HZ, 100000000, module clock frequency.
- PWM_PERIOD_FREQ_HZ, 2000, minimum supported output frequency.
  - MAX_LOW = CLOCK_FREQ_HZ/PWM_PERIOD_FREQ_HZ (50000 at defaults) is the longest permitted low phase. A longer low phase would read as "motor stopped" at the receiver.
- CNT_WIDTH, 32, width of the count fields.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  level. 1 = generate; 0 = stop after the current period completes.
- cfg_high  in  CNT_WIDTH  requested high-phase length, in cycles.
- cfg_low  in  CNT_WIDTH  requested low-phase length, in cycles.
- cfg_valid  in  1  cfg_high/cfg_low are valid.
- cfg_ready  out  1  the pending slot is free. A transfer occurs when cfg_valid && cfg_ready.
- pulse_out  out  1  generated waveform, registered.
- running  out  1  high in the HIGH and LOW states.
- period_done  out  1  one-cycle pulse on the last cycle of each LOW phase.
- cfg_clamped  out  1  one-cycle pulse, the cycle after an accepted config was modified by clamping.

## Operation
- Registers:
  - pending slot: pend_high, pend_low, pend_v.
  - active config: act_high, act_low, act_v.
  - phase counter: cnt.
- State machine: IDLE, HIGH, LOW. Unused encodings return to IDLE.
- Accept: when cfg_valid && cfg_ready:
  - Capture into the pending slot and set pend_v=1. cfg_ready = !pend_v.
  - Clamp on capture: a value of 0 becomes 1; cfg_low > MAX_LOW becomes MAX_LOW.
  - Pulse cfg_clamped next cycle if any clamp was applied.
- Pending to active transfer happens in two places:
  - in IDLE, the cycle after pend_v=1;
  - at every period boundary (last LOW cycle) when pend_v=1.
  - A transfer clears pend_v and sets act_v.
- IDLE:
  - pulse_out=0, running=0.
  - If enable && act_v, go to HIGH with cnt=1.
  - Without act_v, stay in IDLE regardless of enable.
- HIGH:
  - pulse_out=1.
  - When cnt==act_high, go to LOW with cnt=1; otherwise cnt+1.
- LOW:
  - pulse_out=0.
  - When cnt==act_low:
    - assert period_done;
    - load pending if pend_v;
    - if enable, go to HIGH with cnt=1 using the newly loaded values;
    - otherwise go to IDLE.
  - Otherwise cnt+1.
- Deasserting enable mid-period never truncates a phase. The period always completes.
- An accept on the boundary cycle itself lands in pending and applies at the following boundary. An accept on a boundary never bypasses pending.
- Reset mid-operation: state IDLE on the next edge, and all registers cleared.

## Timing
- Reset values: pulse_out=0, running=0, period_done=0, cfg_clamped=0, cfg_ready=1, pend_v=0, act_v=0, cnt=0.
- Start-up from IDLE:
  - config accepted at edge N;
  - active at N+1;
  - with enable held, pulse_out rises at N+2.
- Period length: pulse_out is high for exactly act_high cycles, then low for exactly act_low cycles. The period is act_high+act_low cycles with no gap cycles.
- cfg_ready goes low the cycle after an accept, and returns high the cycle after the pending-to-active transfer.
- period_done coincides with the last low cycle. Next cycle, pulse_out=1 (enable=1) or the block is IDLE (enable=0).
- Width: cnt is CNT_WIDTH bits and compared for equality only. Clamping guarantees act values ≥1, so cnt never wraps.

## Structure
- Shared package/header motor_pkg:
  - state encodings (IDLE=0, HIGH=1, LOW=2);
  - CLOCK_FREQ_HZ / PWM_PERIOD_FREQ_HZ defaults;
  - MAX_LOW derivation, shared with the encoder measurement channel.
- One natural sub-module: enc_cfg_slot.
  - Contains the pending register, clamp logic, cfg_ready and cfg_clamped.
- The FSM and counter stay in the top module.

## Test plan
- Reset, cfg 3/5, enable=1.
  - cfg_ready low for 1 cycle.
  - pulse_out rises 2 cycles after the accept.
  - Pattern repeats 3 high / 5 low.
  - period_done on every 8th cycle.
- Reconfigure to 2/2 mid-HIGH of a 3/5 period.
  - Current period stays 3/5.
  - Next period is 2/2.
  - cfg_ready returns high the cycle after the boundary.
- cfg 0/70000 at defaults.
  - Clamped to 1/50000.
  - cfg_clamped pulses once.
  - Output is 1 high / 50000 low.
- enable drops on the 2nd high cycle of 4/4.
  - Period completes (4 high, 4 low) with period_done.
  - IDLE with pulse_out=0.
  - Re-enable gives a rise 1 cycle later.
- Accept exactly on the period_done cycle (4/4, then 1/1).
  - 4/4 runs one more period.
  - 1/1 applies at the following boundary.
- Reset asserted mid-LOW.
  - Next edge: pulse_out=0, running=0, cfg_ready=1, act_v=0.
  - enable alone does not restart the output.
